ace_req_bridge: RTL
===================

# ace_req_bridge

Translates the cache controller's single-bit transaction requests (`read_req`, `write_req`, `invalid_req`) into simplified ACE read, write and invalidate channel transactions toward the interconnect. When a transaction finishes it returns a one-cycle `ace_ready` completion pulse. It sits between the cache controller/datapath and the interconnect port, and is the responder side of the controller's request/`ace_ready` handshake. It assembles multi-beat read bursts into a full line for the datapath and serialises writeback lines into beats.

## Interface
- `ADDR_WIDTH`, 32, physical address width.
- `DATA_WIDTH`, 32, interconnect data beat width.
- `LINE_WIDTH`, 128, cache line width; must be a power-of-two multiple of `DATA_WIDTH`; `BEATS = LINE_WIDTH/DATA_WIDTH`.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `read_req`, `write_req`, `invalid_req` in 1: requests from the cache controller.
- `req_addr` in ADDR_WIDTH: line address from the datapath.
- `wb_data` in LINE_WIDTH: writeback line from the datapath.
- `ace_ready` out 1: completion pulse to the cache controller.
- `ace_err` out 1: error flag, valid only with `ace_ready`.
- `fill_data` out LINE_WIDTH: assembled read line.
- `ar_addr` out ADDR_WIDTH; `ar_len` out 8; `ar_snoop` out 4; `ar_valid` out 1; `ar_ready` in 1.
- `r_data` in DATA_WIDTH; `r_resp` in 2; `r_last` in 1; `r_valid` in 1; `r_ready` out 1.
- `aw_addr` out ADDR_WIDTH; `aw_len` out 8; `aw_snoop` out 3; `aw_valid` out 1; `aw_ready` in 1.
- `w_data` out DATA_WIDTH; `w_last` out 1; `w_valid` out 1; `w_ready` in 1.
- `b_resp` in 2; `b_valid` in 1; `b_ready` out 1.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, INV_ADDR, INV_RESP.
- In IDLE, requests are sampled. Priority is `write_req` > `invalid_req` > `read_req`. On acceptance, `req_addr` (with the line-offset bits forced to 0) and `wb_data` are captured into internal registers.
- Requests outside IDLE are ignored. The controller re-asserting `read_req` while waiting has no effect.
- Read: IDLE→RD_ADDR. Drive `ar_snoop`=4'b0001 (ReadShared) and `ar_len`=BEATS-1. On `ar_valid&&ar_ready`, go to RD_DATA.
  - RD_DATA: `r_ready`=1. Each `r_valid` beat k is written into `fill_data[k*DATA_WIDTH +: DATA_WIDTH]`. The beat counter saturates at BEATS-1.
  - On `r_last`: pulse `ace_ready` and return to IDLE.
- Writeback: IDLE→WR_ADDR. Drive `aw_snoop`=3'b011 (WriteBack) and `aw_len`=BEATS-1. On handshake, go to WR_DATA.
  - WR_DATA: send beats 0..BEATS-1 in order. Advance on `w_valid&&w_ready`. `w_last` is high on beat BEATS-1. After the last beat, go to WR_RESP.
  - WR_RESP: `b_ready`=1. On `b_valid`, pulse `ace_ready` and return to IDLE.
- Invalidate: IDLE→INV_ADDR. Drive `ar_snoop`=4'b1011 (CleanUnique) and `ar_len`=0. On handshake, go to INV_RESP.
  - INV_RESP: `r_ready`=1. On the `r_valid&&r_last` beat, pulse `ace_ready` and return to IDLE. The data beat is discarded.
- Valid rules:
  - No valid deasserts before its ready.
  - Address, data and snoop fields stay stable while their valid is high.
- `ace_err` is set with `ace_ready` in either case:
  - Any response beat of the transaction carried `r_resp`/`b_resp` ≠ 2'b00.
  - A read `r_last` arrived on a beat index ≠ BEATS-1.
- `fill_data` holds its value until the next read's first beat.

## Timing
- Reset values: all valids and readies 0, `ace_ready`=0, `ace_err`=0, `fill_data`=0, `w_last`=0, state IDLE.
- Latency: the address valid asserts in the cycle after the request is sampled. `ace_ready` asserts in the cycle after the final `r`/`b` handshake and lasts exactly one cycle.
- Minimum read latency, request to `ace_ready`: 2+BEATS cycles with zero-wait interconnect.
- The FSM returns to IDLE in the same cycle as the `ace_ready` pulse, so a new request is accepted on the next edge.
- A `reset` asserted mid-transaction clears state, valids and the beat counter immediately. No `ace_ready` is issued, and the interconnect transaction is abandoned.

## Configuration
- `ACE_ERR_RETRY_EN` defined:
  - A transaction ending with an error response is reissued from its address state, at most 2 times, using the captured address and data.
  - `ace_ready` pulses only on success or after the final failed retry; `ace_err`=1 only in the final-failure case.
- `ACE_ERR_RETRY_EN` undefined: no retry. Errors complete immediately with `ace_err`=1.

## Test plan
- Read: `read_req`, `req_addr`=0x1000_0004, 4 beats 0xA0..0xA3 with OKAY → `ar_addr`=0x1000_0000, `ar_snoop`=0001, `ar_len`=3, `fill_data`=0x000000A3_000000A2_000000A1_000000A0, one `ace_ready` pulse, `ace_err`=0.
- Writeback with `w_ready` stalled 2 cycles on beat 1 → `w_data` stable through the stall, `w_last` only on beat 3, `aw_snoop`=011, `ace_ready` one cycle after `b_valid`.
- Invalidate: `invalid_req` with `ar_ready` low 3 cycles → `ar_valid` held with `ar_snoop`=1011 and `ar_len`=0; the single R beat yields `ace_ready`.
- Simultaneous `write_req`+`read_req` in IDLE → only the AW transaction is issued.
- `r_resp`=2'b10 on beat 2 → without the macro, `ace_err`=1 with `ace_ready`; with `ACE_ERR_RETRY_EN`, a second `ar_valid` is issued, and success on the retry gives `ace_err`=0.
- `reset` asserted during WR_DATA beat 1 → `w_valid`=0 immediately, no `ace_ready`; a following `read_req` completes normally.

Source files
------------

// File: rtl/ace_req_bridge_if.sv
// Purpose  : simplified ACE channel bundle (AR/R/AW/W/B) between the request bridge and the interconnect.
// Latency  : none; this is wiring only.
// Backpress: each channel uses valid/ready; the side that owns valid must hold it until ready.
// Ports    : master = bridge side (drives AR/AW/W, r_ready, b_ready);
//            slave  = interconnect side (drives R/B, ar_ready, aw_ready, w_ready).
interface ace_req_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Read address / invalidate address
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [3:0]            ar_snoop;
  logic                  ar_valid;
  logic                  ar_ready;
  // Read data / invalidate response
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic                  r_valid;
  logic                  r_ready;
  // Write address
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_snoop;
  logic                  aw_valid;
  logic                  aw_ready;
  // Write data
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;
  logic                  w_valid;
  logic                  w_ready;
  // Write response
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  modport master (
    output ar_addr, ar_len, ar_snoop, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_last, r_valid,
    output r_ready,
    output aw_addr, aw_len, aw_snoop, aw_valid,
    input  aw_ready,
    output w_data, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready
  );

  modport slave (
    input  ar_addr, ar_len, ar_snoop, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_last, r_valid,
    input  r_ready,
    input  aw_addr, aw_len, aw_snoop, aw_valid,
    output aw_ready,
    input  w_data, w_last, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready
  );
endinterface

// File: rtl/ace_req_bridge.sv
// Purpose  : turns cache-controller read/write/invalidate requests into ACE AR/R, AW/W/B transactions and
//            returns a one-cycle ace_ready completion pulse (with ace_err) to the controller.
// Latency  : address valid one cycle after the request is sampled; ace_ready one cycle after the final R/B
//            handshake (zero-wait read: 2+BEATS cycles request to ace_ready).
// Backpress: valids are held until their ready; the bridge only ever stalls by not issuing, it never drops.
// Ports    : clk/reset (async, active-high); read_req/write_req/invalid_req, req_addr, wb_data from the
//            controller/datapath; ace_ready, ace_err, fill_data back to them; bus = ACE master modport.
// Option   : define ACE_ERR_RETRY_EN to reissue an errored transaction up to 2 times before reporting it.
module ace_req_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic                  invalid_req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] wb_data,
  output logic                  ace_ready,
  output logic                  ace_err,
  output logic [LINE_WIDTH-1:0] fill_data,
  ace_req_bridge_if.master      bus
);

  localparam int BEATS    = LINE_WIDTH / DATA_WIDTH;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [7:0]            BURST_LEN = 8'(BEATS - 1);
  // Clears the byte-offset-within-line bits of the request address.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ADDR  = 3'd1;
  localparam logic [2:0] ST_RD_DATA  = 3'd2;
  localparam logic [2:0] ST_WR_ADDR  = 3'd3;
  localparam logic [2:0] ST_WR_DATA  = 3'd4;
  localparam logic [2:0] ST_WR_RESP  = 3'd5;
  localparam logic [2:0] ST_INV_ADDR = 3'd6;
  localparam logic [2:0] ST_INV_RESP = 3'd7;

  logic [2:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [LINE_WIDTH-1:0] line_q,      line_d;
  logic [LINE_WIDTH-1:0] fill_q,      fill_d;
  logic [BEAT_W-1:0]     beat_q,      beat_d;
  logic                  err_q,       err_d;
  logic                  ace_ready_q, ace_ready_d;
  logic                  ace_err_q,   ace_err_d;
`ifdef ACE_ERR_RETRY_EN
  logic [1:0]            retry_q,     retry_d;
  logic [2:0]            restart_st;
`endif

  // Final response handshake of the current attempt, and whether that attempt failed.
  logic                  fin;
  logic                  fin_err;
  logic [BEAT_W-1:0]     beat_inc;
  logic [DATA_WIDTH-1:0] w_beat;

  // Read beat counter sticks at the last index so an over-long burst cannot wrap into beat 0.
  assign beat_inc = (beat_q == LAST_BEAT) ? beat_q : beat_q + 1'b1;

  always_comb begin
    w_beat = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BEAT_W'(k)) begin
        w_beat = line_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    line_d      = line_q;
    fill_d      = fill_q;
    beat_d      = beat_q;
    err_d       = err_q;
    ace_ready_d = 1'b0;
    ace_err_d   = 1'b0;
    fin         = 1'b0;
    fin_err     = 1'b0;
`ifdef ACE_ERR_RETRY_EN
    retry_d     = retry_q;
    restart_st  = ST_IDLE;
`endif

    case (state_q)
      ST_IDLE: begin
        if (write_req || invalid_req || read_req) begin
          addr_d = req_addr & LINE_MASK;
          line_d = wb_data;
          beat_d = '0;
          err_d  = 1'b0;
`ifdef ACE_ERR_RETRY_EN
          retry_d = 2'd0;
`endif
          if (write_req) begin
            state_d = ST_WR_ADDR;
          end else if (invalid_req) begin
            state_d = ST_INV_ADDR;
          end else begin
            state_d = ST_RD_ADDR;
          end
        end
      end

      ST_RD_ADDR: begin
        if (bus.ar_ready) begin
          state_d = ST_RD_DATA;
          beat_d  = '0;
        end
      end

      ST_RD_DATA: begin
        if (bus.r_valid) begin
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) begin
              fill_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.r_data;
            end
          end
          beat_d = beat_inc;
          err_d  = err_q | (bus.r_resp != 2'b00);
          if (bus.r_last) begin
            fin     = 1'b1;
            // A short burst leaves the line partially stale, so it is reported as an error.
            fin_err = err_q | (bus.r_resp != 2'b00) | (beat_q != LAST_BEAT);
          end
        end
      end

      ST_WR_ADDR: begin
        if (bus.aw_ready) begin
          state_d = ST_WR_DATA;
          beat_d  = '0;
        end
      end

      ST_WR_DATA: begin
        if (bus.w_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_WR_RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      ST_WR_RESP: begin
        if (bus.b_valid) begin
          fin     = 1'b1;
          fin_err = bus.b_resp != 2'b00;
        end
      end

      ST_INV_ADDR: begin
        if (bus.ar_ready) begin
          state_d = ST_INV_RESP;
        end
      end

      ST_INV_RESP: begin
        // Data carried with the CleanUnique response is not needed by the cache; only resp matters.
        if (bus.r_valid) begin
          err_d = err_q | (bus.r_resp != 2'b00);
          if (bus.r_last) begin
            fin     = 1'b1;
            fin_err = err_q | (bus.r_resp != 2'b00);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
`ifdef ACE_ERR_RETRY_EN
      case (state_q)
        ST_RD_DATA:  restart_st = ST_RD_ADDR;
        ST_WR_RESP:  restart_st = ST_WR_ADDR;
        ST_INV_RESP: restart_st = ST_INV_ADDR;
        default:     restart_st = ST_IDLE;
      endcase
      if (fin_err && (retry_q != 2'd2)) begin
        // Replay from the address phase with the captured address/line; the controller sees nothing.
        retry_d = retry_q + 2'd1;
        state_d = restart_st;
        beat_d  = '0;
        err_d   = 1'b0;
      end else begin
        state_d     = ST_IDLE;
        ace_ready_d = 1'b1;
        ace_err_d   = fin_err;
      end
`else
      state_d     = ST_IDLE;
      ace_ready_d = 1'b1;
      ace_err_d   = fin_err;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      line_q      <= '0;
      fill_q      <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      ace_ready_q <= 1'b0;
      ace_err_q   <= 1'b0;
`ifdef ACE_ERR_RETRY_EN
      retry_q     <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      line_q      <= line_d;
      fill_q      <= fill_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      ace_ready_q <= ace_ready_d;
      ace_err_q   <= ace_err_d;
`ifdef ACE_ERR_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  // Channel outputs decode straight from registered state, so they drop the instant reset asserts
  // and stay stable for as long as the state holds waiting for ready.
  assign bus.ar_valid = (state_q == ST_RD_ADDR) || (state_q == ST_INV_ADDR);
  assign bus.ar_addr  = addr_q;
  assign bus.ar_len   = (state_q == ST_INV_ADDR) ? 8'd0 : BURST_LEN;
  assign bus.ar_snoop = (state_q == ST_INV_ADDR) ? 4'b1011 : 4'b0001;
  assign bus.r_ready  = (state_q == ST_RD_DATA) || (state_q == ST_INV_RESP);

  assign bus.aw_valid = (state_q == ST_WR_ADDR);
  assign bus.aw_addr  = addr_q;
  assign bus.aw_len   = BURST_LEN;
  assign bus.aw_snoop = 3'b011;

  assign bus.w_valid  = (state_q == ST_WR_DATA);
  assign bus.w_data   = w_beat;
  assign bus.w_last   = (state_q == ST_WR_DATA) && (beat_q == LAST_BEAT);
  assign bus.b_ready  = (state_q == ST_WR_RESP);

  assign ace_ready    = ace_ready_q;
  assign ace_err      = ace_err_q;
  assign fill_data    = fill_q;

endmodule
